// File: rtl/vector_reduce_accumulator.sv
// vector_reduce_accumulator
//   Reduces each accepted beat of LANES unsigned elements to one lane sum,
//   then accumulates lane sums across a packet with saturation. The
//   packet result is presented on a valid/ready output port. One cycle
//   of pipelining sits between the input handshake and the accumulator.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  input beat handshake (ready only in the accumulate state)
//   in_data            LANES packed unsigned elements of DATA_WIDTH bits
//   in_last            final beat of a packet, qualified by the handshake
//   out_valid/ready    result handshake
//   out_sum            saturated packet sum
//   out_beats          beats in the packet (saturating at 16'hFFFF)
//   out_overflow       the accumulator saturated somewhere in the packet
module vector_reduce_accumulator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 8,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]     in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ACC_WIDTH-1:0]                 out_sum,
  output logic [15:0]                          out_beats,
  output logic                                 out_overflow
);

  localparam int unsigned SumWidth = DATA_WIDTH + $clog2(LANES);
  localparam int unsigned ExtWidth = ACC_WIDTH + 1;

  typedef enum logic [1:0] {StAccum, StFlush, StHold} state_e;

  state_e                 state_q, state_d;
  logic [SumWidth-1:0]    pipe_sum_q;
  logic                   pipe_valid_q;
  logic                   pipe_last_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic                   ovf_q;
  logic [15:0]            count_q;
  logic [ACC_WIDTH-1:0]   out_sum_q;
  logic [15:0]            out_beats_q;
  logic                   out_overflow_q;

  logic                   accept;
  logic [SumWidth-1:0]    lane_sum;
  logic [ExtWidth-1:0]    acc_ext;
  logic                   sat_hit;
  logic [ACC_WIDTH-1:0]   acc_sat;
  logic [15:0]            count_inc;

  // Ready is suppressed combinationally while reset is asserted.
  assign in_ready  = (state_q == StAccum) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StHold);

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_sum = lane_sum + SumWidth'(in_data[i]);
    end
  end

  // One extra bit catches the carry out; a carry means clamp to all-ones.
  assign acc_ext   = {1'b0, acc_q} + ExtWidth'(pipe_sum_q);
  assign sat_hit   = acc_ext[ACC_WIDTH];
  assign acc_sat   = sat_hit ? '1 : acc_ext[ACC_WIDTH-1:0];
  assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (accept && in_last) state_d = StFlush;
      StFlush: state_d = StHold;
      StHold:  if (out_ready) state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StAccum;
      pipe_sum_q     <= '0;
      pipe_valid_q   <= 1'b0;
      pipe_last_q    <= 1'b0;
      acc_q          <= '0;
      ovf_q          <= 1'b0;
      count_q        <= '0;
      out_sum_q      <= '0;
      out_beats_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;

      // Stage 1: lane reduction and beat counting.
      pipe_valid_q <= accept;
      if (accept) begin
        pipe_sum_q  <= lane_sum;
        pipe_last_q <= in_last;
        if (in_last) begin
          out_beats_q <= count_inc;
          count_q     <= '0;
        end else begin
          count_q <= count_inc;
        end
      end

      // Stage 2: saturating accumulation; the last beat publishes and clears.
      if (pipe_valid_q) begin
        if (pipe_last_q) begin
          out_sum_q      <= acc_sat;
          out_overflow_q <= ovf_q | sat_hit;
          acc_q          <= '0;
          ovf_q          <= 1'b0;
        end else begin
          acc_q <= acc_sat;
          ovf_q <= ovf_q | sat_hit;
        end
      end
    end
  end

  assign out_sum      = out_sum_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_vector_reduce_accumulator.sv
module tb_vector_reduce_accumulator;

  localparam int unsigned DW = 8;
  localparam int unsigned LN = 8;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic [LN-1:0][DW-1:0] in_data;
  logic in_ready, out_valid, out_overflow;
  logic [31:0] out_sum;
  logic [15:0] out_beats;
  logic in_ready12, out_valid12, out_overflow12;
  logic [11:0] out_sum12;
  logic [15:0] out_beats12;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vector_reduce_accumulator #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_beats(out_beats), .out_overflow(out_overflow)
  );

  vector_reduce_accumulator #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid12), .out_ready(out_ready), .out_sum(out_sum12),
    .out_beats(out_beats12), .out_overflow(out_overflow12)
  );

  typedef struct packed {
    logic [2:0]      nb;
    logic [3:0][7:0] v;    // uniform lane value per beat, v[0] first
    logic [31:0]     s32;
    logic [11:0]     s12;
    logic            o12;
  } vec_t;

  typedef struct {
    longint s32;
    longint s12;
    logic   o12;
    int     beats;
  } exp_t;

  vec_t tbl[6];
  exp_t exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d required %0d", nm, act, req);
  endtask

  task automatic scramble();
    for (int l = 0; l < int'(LN); l++) in_data[l] = 8'($urandom_range(0, 255));
    in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic beat(input logic [7:0] v, input logic last);
    in_valid = 1'b1;
    in_data  = {LN{v}};
    in_last  = last;
    step();
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic run_entry(input vec_t e, input int idx);
    string tag;
    tag = $sformatf("tbl%0d", idx);
    for (int b = 0; b < int'(e.nb); b++) begin
      wait_ready();
      beat(e.v[b], (b == int'(e.nb) - 1));
      if (b != int'(e.nb) - 1) step();
    end
    chk({tag, "_flush_valid"}, 64'(out_valid), 0);
    chk({tag, "_flush_ready"}, 64'(in_ready), 0);
    step();
    chk({tag, "_valid"}, 64'(out_valid), 1);
    chk({tag, "_sum"}, 64'(out_sum), 64'(e.s32));
    chk({tag, "_beats"}, 64'(out_beats), 64'(e.nb));
    chk({tag, "_ovf"}, 64'(out_overflow), 0);
    chk({tag, "_sum12"}, 64'(out_sum12), 64'(e.s12));
    chk({tag, "_ovf12"}, 64'(out_overflow12), 64'(e.o12));
    step();
    chk({tag, "_ready_after"}, 64'(in_ready), 1);
  endtask

  initial begin
    longint tot;
    int pk, bi, len, blocked, cyc;
    exp_t e;

    tbl[0] = '{nb: 3'd1, v: {8'h00, 8'h00, 8'h00, 8'hFF}, s32: 32'd2040, s12: 12'd2040, o12: 1'b0};
    tbl[1] = '{nb: 3'd3, v: {8'h00, 8'h03, 8'h02, 8'h01}, s32: 32'd48, s12: 12'd48, o12: 1'b0};
    tbl[2] = '{nb: 3'd3, v: {8'h00, 8'hFF, 8'hFF, 8'hFF}, s32: 32'd6120, s12: 12'd4095, o12: 1'b1};
    tbl[3] = '{nb: 3'd1, v: {8'h00, 8'h00, 8'h00, 8'h01}, s32: 32'd8, s12: 12'd8, o12: 1'b0};
    tbl[4] = '{nb: 3'd2, v: {8'h00, 8'h00, 8'h20, 8'h10}, s32: 32'd384, s12: 12'd384, o12: 1'b0};
    tbl[5] = '{nb: 3'd4, v: {8'h80, 8'h80, 8'h80, 8'h80}, s32: 32'd4096, s12: 12'd4095, o12: 1'b1};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    scramble();
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_sum", 64'(out_sum), 0);
    chk("rst_out_beats", 64'(out_beats), 0);
    chk("rst_out_ovf", 64'(out_overflow), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 1);

    for (int i = 0; i < 6; i++) run_entry(tbl[i], i);

    // Consumer stalls in HOLD for 5 cycles
    out_ready = 1'b0;
    wait_ready();
    beat(8'h05, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(out_valid), 1);
      chk("stall_sum", 64'(out_sum), 40);
      chk("stall_ready", 64'(in_ready), 0);
      step();
    end
    chk("stall_sum_end", 64'(out_sum), 40);
    out_ready = 1'b1;
    step();
    chk("release_ready", 64'(in_ready), 1);
    chk("release_valid", 64'(out_valid), 0);

    // Reset while holding a result discards it
    out_ready = 1'b0;
    beat(8'h07, 1'b1);
    step();
    rst = 1'b1;
    #1;
    chk("hold_rst_ready", 64'(in_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("hold_rst_valid", 64'(out_valid), 0);
    chk("hold_rst_sum", 64'(out_sum), 0);
    chk("hold_rst_beats", 64'(out_beats), 0);
    chk("hold_rst_in_ready", 64'(in_ready), 1);
    out_ready = 1'b1;

    // Reset mid-packet discards the partial sum
    beat(8'h10, 1'b0);
    beat(8'h10, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 1);
    beat(8'h01, 1'b1);
    step();
    chk("mid_rst_valid", 64'(out_valid), 1);
    chk("mid_rst_sum", 64'(out_sum), 8);
    chk("mid_rst_beats", 64'(out_beats), 1);
    chk("mid_rst_ovf", 64'(out_overflow), 0);
    step();

    // Back-to-back random packets with in_valid held high
    pk = 0; bi = 0; tot = 0; blocked = 0; cyc = 0;
    len = $urandom_range(1, 5);
    while ((pk < 40 || exp_q.size() > 0) && cyc < 3000) begin
      chk("rnd_in_ready", 64'(in_ready), 64'(blocked == 0));
      if (blocked > 0) blocked--;
      if (pk < 40) begin
        in_valid = 1'b1;
        for (int l = 0; l < int'(LN); l++) in_data[l] = 8'($urandom_range(0, 255));
        in_last = (bi == len - 1);
        if (in_ready) begin
          for (int l = 0; l < int'(LN); l++) tot += longint'(in_data[l]);
          if (bi == len - 1) begin
            e.s32   = (tot > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : tot;
            e.s12   = (tot > 4095) ? 4095 : tot;
            e.o12   = (tot > 4095);
            e.beats = len;
            exp_q.push_back(e);
            pk++; bi = 0; tot = 0; blocked = 2;
            len = $urandom_range(1, 5);
          end else begin
            bi++;
          end
        end
      end else begin
        in_valid = 1'b0;
      end
      step();
      cyc++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_sum", 64'(out_sum), 64'(e.s32));
          chk("rnd_beats", 64'(out_beats), 64'(e.beats));
          chk("rnd_ovf", 64'(out_overflow), 0);
          chk("rnd_sum12", 64'(out_sum12), 64'(e.s12));
          chk("rnd_ovf12", 64'(out_overflow12), 64'(e.o12));
        end
      end
    end
    in_valid = 1'b0;
    if (cyc >= 3000) chk("rnd_timeout", 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
